dig_inp_filter_multi: RTL and testbench
=======================================

// Module: dig_inp_filter_multi
// PURPOSE
//  Multi-channel digital input debounce filter for the MAX1000 motion-control FPGA (50 MHz).
//  - Synchronises CHANNELS asynchronous pins and filters each with a per-channel consecutive-sample counter.
//  - filt_len is runtime-programmable; 0 or 1 gives bypass.
//  - Adds one-cycle rise/fall strobes and sticky per-channel change flags for the register/IRQ logic.
// PARAMETERS
//  CHANNELS     8       number of independent input channels
//  CNT_W        8       filter counter width; max filter length 2**CNT_W-1 clocks
//  SYNC_STAGES  2       synchroniser flip-flops per channel (>=2)
//  INIT         {CHANNELS{1'b0}}  reset value of synchroniser, out and internal state per channel
// PORTS
//  clk       in   1         system clock, 50 MHz, all logic on rising edge
//  reset_n   in   1         synchronous reset, active-low
//  in        in   CHANNELS  raw asynchronous input pins
//  filt_len  in   CNT_W     required consecutive stable clocks before out follows (shared by all channels)
//  out       out  CHANNELS  filtered level
//  rise      out  CHANNELS  1-clk strobe, out[i] went 0->1 this cycle
//  fall      out  CHANNELS  1-clk strobe, out[i] went 1->0 this cycle
//  evt       out  CHANNELS  sticky: out[i] changed since last clear
//  evt_clr   in   CHANNELS  1-clk clear request for evt[i]
// BEHAVIOUR
//  Reset (reset_n=0 at rising clk): sync chain=INIT, out=INIT, cnt=0, rise=fall=0, evt=0. No strobe on reset release.
//  Sync: in[i] shifts through SYNC_STAGES FFs; the last stage is in_s[i].
//  Effective length L = (filt_len==0) ? 1 : filt_len.
//  Per channel, each clock:
//   - in_s==out: cnt<=0.
//   - in_s!=out and cnt>=L-1: out<=in_s, cnt<=0, rise/fall strobe asserted in the same cycle out changes.
//   - otherwise: cnt<=cnt+1.
//  Latency: pin stable from before edge k -> out updates at edge k+SYNC_STAGES-1+L (k+1+L for SYNC_STAGES=2).
//  Glitch of fewer than L sampled clocks: counter restarts and out is unchanged (no strobe).
//  filt_len change mid-count: takes effect immediately.
//   - If cnt already >= new L-1, out updates on the next mismatching clock.
//   - cnt never wraps; the compare is >=, not ==.
//  rise/fall are registered, asserted exactly one clock, mutually exclusive per channel.
//  evt[i] is set on any out[i] change. evt_clr[i]=1 clears it.
//   - Simultaneous change and clear: set wins (evt stays 1).
//  Channels are fully independent; any number may switch in the same cycle.
//  Reset mid-count: discards the pending transition; out returns to INIT.
// STRUCTURE
//  Package dig_inp_pkg:
//   - DIG_INP_CNT_W_DEF=8
//   - DIG_INP_SYNC_DEF=2
//   - filter-length constants in clocks, e.g. FILT_100NS=5, FILT_1US=50.
//  Sub-module dig_inp_filter_ch: one channel (sync chain, counter, out, rise/fall, evt).
//  Top instantiates dig_inp_filter_ch CHANNELS times with a generate loop; filt_len is broadcast.
// TESTING  (CHANNELS=4, CNT_W=5, SYNC_STAGES=2, INIT=0, clk period 20 ns)
//  1. Reset: hold reset_n=0 with in=4'hF for 3 clks -> out=0, rise=fall=evt=0.
//     Release with in=0 -> no strobe.
//  2. filt_len=5, in[0] 0->1 and stable -> out[0]=1 exactly 6 clks after the first sampling edge.
//     rise[0] high for 1 clk; evt[0]=1.
//  3. filt_len=5, in[1] pulses high for 4 clks, low 5 clks, high 4 clks -> out[1] stays 0, no strobes.
//     A 5-clk pulse then toggles out[1] (and back after it ends), with rise then fall.
//  4. filt_len=0 and filt_len=1: in[2] toggles every 3 clks -> out[2] follows with 2-clk latency.
//     One strobe per toggle.
//  5. Set filt_len=20, start in[3] change, after 8 clks write filt_len=5 -> out[3] updates on the next clk.
//  6. Assert evt_clr[0] on the same clk as a fall[0] -> evt[0] stays 1.
//     A later lone evt_clr[0] clears it.
//     Assert reset_n=0 mid-count -> pending change discarded.

Source files
------------

// File: rtl/dig_inp_pkg.sv
// Shared defaults and filter-length presets for the digital input debounce filter.
package dig_inp_pkg;

  localparam int unsigned DIG_INP_CNT_W_DEF = 8;
  localparam int unsigned DIG_INP_SYNC_DEF  = 2;

  // Filter lengths in 50 MHz clocks
  localparam int unsigned FILT_100NS = 5;
  localparam int unsigned FILT_1US   = 50;
  localparam int unsigned FILT_5US   = 250;

endpackage

// File: rtl/dig_inp_filter_ch.sv
// One debounce channel: synchroniser, consecutive-sample counter, filtered level,
// edge strobes and a sticky change flag.
module dig_inp_filter_ch
  import dig_inp_pkg::*;
#(
  parameter int unsigned CNT_W       = DIG_INP_CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = DIG_INP_SYNC_DEF,
  parameter logic        INIT        = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in,
  input  logic [CNT_W-1:0] filt_len,
  input  logic             evt_clr,
  output logic             out,
  output logic             rise,
  output logic             fall,
  output logic             evt
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       len_m1_c;
  logic                   in_s;
  logic                   flip_c;

  assign in_s     = sync[SYNC_STAGES-1];
  // Lengths 0 and 1 both mean "follow on the first mismatching sample"
  assign len_m1_c = (filt_len == '0) ? '0 : filt_len - CNT_W'(1);
  // >= rather than == so a shortened length mid-count still lets out follow
  assign flip_c   = (in_s != out) && (cnt >= len_m1_c);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= {SYNC_STAGES{INIT}};
      out  <= INIT;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
      evt  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
      rise <= flip_c & in_s;
      fall <= flip_c & ~in_s;

      if (in_s == out) begin
        cnt <= '0;
      end else if (flip_c) begin
        out <= in_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // A change in the same cycle as a clear keeps the flag set
      if (flip_c) begin
        evt <= 1'b1;
      end else if (evt_clr) begin
        evt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dig_inp_filter_multi.sv
// Multi-channel debounce filter: independent channels sharing one programmable filter length.
module dig_inp_filter_multi
  import dig_inp_pkg::*;
#(
  parameter int unsigned          CHANNELS    = 8,
  parameter int unsigned          CNT_W       = DIG_INP_CNT_W_DEF,
  parameter int unsigned          SYNC_STAGES = DIG_INP_SYNC_DEF,
  parameter logic [CHANNELS-1:0]  INIT        = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  input  logic [CNT_W-1:0]    filt_len,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] evt,
  input  logic [CHANNELS-1:0] evt_clr
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    dig_inp_filter_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT        (INIT[g])
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .in       (in[g]),
      .filt_len (filt_len),
      .evt_clr  (evt_clr[g]),
      .out      (out[g]),
      .rise     (rise[g]),
      .fall     (fall[g]),
      .evt      (evt[g])
    );
  end

endmodule

// File: tb/tb_dig_inp_filter_multi.sv
// Bench for dig_inp_filter_multi: directed scenarios plus random pins, all checked
// against a per-channel mismatch-streak model of the debounce rules.
module tb_dig_inp_filter_multi;

  localparam int unsigned CH    = 4;
  localparam int unsigned CW    = 5;
  localparam int unsigned SYNC  = 2;

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] din;
  logic [CW-1:0] filt_len;
  logic [CH-1:0] dout;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] evt;
  logic [CH-1:0] evt_clr;

  int n_tests = 0;
  int n_fail  = 0;

  dig_inp_filter_multi #(
    .CHANNELS    (CH),
    .CNT_W       (CW),
    .SYNC_STAGES (SYNC),
    .INIT        ('0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (din),
    .filt_len (filt_len),
    .out      (dout),
    .rise     (rise),
    .fall     (fall),
    .evt      (evt),
    .evt_clr  (evt_clr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin value seen SYNC clocks ago, and how many consecutive
  // earlier clocks that delayed pin disagreed with the filtered level.
  logic          m_valid = 1'b0;
  logic          pipe [CH][SYNC];
  int            streak [CH];
  logic [CH-1:0] m_out, m_rise, m_fall, m_evt;

  always @(posedge clk) begin
    int   len;
    logic seen;
    if (!reset_n) begin
      m_valid = 1'b1;
      m_out = '0; m_rise = '0; m_fall = '0; m_evt = '0;
      for (int c = 0; c < CH; c++) begin
        streak[c] = 0;
        for (int s = 0; s < SYNC; s++) pipe[c][s] = 1'b0;
      end
    end else begin
      len = (filt_len == 0) ? 1 : int'(filt_len);
      for (int c = 0; c < CH; c++) begin
        seen = pipe[c][SYNC-1];
        for (int s = SYNC - 1; s > 0; s--) pipe[c][s] = pipe[c][s-1];
        pipe[c][0] = din[c];
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (seen == m_out[c]) begin
          streak[c] = 0;
          if (evt_clr[c]) m_evt[c] = 1'b0;
        end else if (streak[c] + 1 >= len) begin
          m_out[c]  = seen;
          m_rise[c] = seen;
          m_fall[c] = ~seen;
          m_evt[c]  = 1'b1;
          streak[c] = 0;
        end else begin
          streak[c] = streak[c] + 1;
          if (evt_clr[c]) m_evt[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("out",  32'(dout), 32'(m_out));
      chk("rise", 32'(rise), 32'(m_rise));
      chk("fall", 32'(fall), 32'(m_fall));
      chk("evt",  32'(evt),  32'(m_evt));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clocks after the first sampling edge until out[ch]==val; -1 on timeout.
  task automatic wait_out(input int ch, input logic val, input int max, output int cyc);
    @(posedge clk);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (dout[ch] !== val && cyc < max);
    if (dout[ch] !== val) cyc = -1;
  endtask

  initial begin
    int c;
    reset_n  = 1'b0;
    din      = 4'hF;
    filt_len = '0;
    evt_clr  = '0;

    // Reset with all pins high
    tick(3);
    chk("rst_out", 32'(dout), 0);
    chk("rst_evt", 32'(evt), 0);
    chk("rst_strobe", 32'(rise | fall), 0);
    reset_n = 1'b1;
    din     = '0;
    tick(3);
    chk("release_strobe", 32'(rise | fall), 0);

    // Stable change on ch0, length 5
    filt_len = 5'd5;
    din[0]   = 1'b1;
    wait_out(0, 1'b1, 20, c);
    chk("lat_len5", 32'(c), 6);
    chk("rise0", 32'(rise[0]), 1);
    chk("evt0", 32'(evt[0]), 1);
    @(negedge clk);

    // Short glitches on ch1 must be ignored
    din[1] = 1'b1; tick(4);
    din[1] = 1'b0; tick(5);
    din[1] = 1'b1; tick(4);
    din[1] = 1'b0; tick(10);
    chk("glitch_out1", 32'(dout[1]), 0);
    chk("glitch_evt1", 32'(evt[1]), 0);

    // 5-clock pulse passes through and returns
    din[1] = 1'b1; tick(5);
    din[1] = 1'b0;
    wait_out(1, 1'b1, 10, c);
    chk("p5_rise_lat", 32'(c), 1);
    chk("p5_rise", 32'(rise[1]), 1);
    wait_out(1, 1'b0, 12, c);
    chk("p5_fall_lat", 32'(c), 4);
    chk("p5_fall", 32'(fall[1]), 1);
    @(negedge clk);

    // Bypass lengths 0 and 1: two-clock latency on every toggle
    for (int fl = 0; fl < 2; fl++) begin
      filt_len = CW'(fl);
      tick(2);
      for (int t = 0; t < 4; t++) begin
        din[2] = ~din[2];
        wait_out(2, din[2], 8, c);
        chk("bypass_lat", 32'(c), 2);
        @(negedge clk);
      end
    end

    // Shortening the length mid-count lets out follow on the next clock
    filt_len = 5'd20;
    din[3]   = 1'b1;
    tick(8);
    chk("long_pending", 32'(dout[3]), 0);
    filt_len = 5'd5;
    @(posedge clk); #1;
    chk("shorten_out3", 32'(dout[3]), 1);
    @(negedge clk);

    // Sticky flag: lone clear, clear colliding with a change, then lone clear
    evt_clr[0] = 1'b1; tick(1);
    evt_clr[0] = 1'b0;
    chk("clr_lone1", 32'(evt[0]), 0);
    din[0] = 1'b0;
    tick(6);
    evt_clr[0] = 1'b1; tick(1);
    evt_clr[0] = 1'b0;
    chk("clr_fall0", 32'(fall[0]), 1);
    chk("clr_set_wins", 32'(evt[0]), 1);
    tick(2);
    evt_clr[0] = 1'b1; tick(1);
    evt_clr[0] = 1'b0;
    chk("clr_lone2", 32'(evt[0]), 0);

    // Reset in the middle of a pending change
    din[1] = 1'b1;
    tick(4);
    reset_n = 1'b0;
    din     = '0;
    tick(1);
    reset_n = 1'b1;
    tick(10);
    chk("midrst_out", 32'(dout), 0);
    chk("midrst_evt", 32'(evt), 0);

    // Random pins, lengths and clears against the model
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < CH; b++)
        if ($urandom_range(4, 0) == 0) din[b] = ~din[b];
      evt_clr = CH'($urandom_range(15, 0) & $urandom_range(15, 0));
      if (i % 60 == 0) filt_len = CW'($urandom_range(7, 0));
      if (i % 250 == 125) filt_len = CW'($urandom_range(31, 16));
      reset_n = ($urandom_range(299, 0) != 0);
      tick(1);
    end
    reset_n = 1'b1;
    evt_clr = '0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
